// File: rtl/dffre_pipe_pkg.sv
// Shared helpers for the dffre_pipe_vr elastic register pipeline:
// counter sizing, the default reset pattern and the occupancy-update encoding.
package dffre_pipe_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/dffre_pipe_stage.sv
// One pipeline stage: a valid flop plus a WIDTH-bit data flop with
// async reset, sync clear, load and drain controls.
module dffre_pipe_stage
    import dffre_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(all_ones(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset too, not just valid: RESET_VAL is observable on out_data while the stage is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dffre_pipe_vr.sv
// DEPTH-stage elastic register pipeline with val/rdy on both sides, bubble collapsing,
// stall and flush. Define DFFRE_PIPE_VR_BYPASS_EN for a same-cycle in-to-out path when empty.
module dffre_pipe_vr
    import dffre_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(all_ones(WIDTH))
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [WIDTH-1:0]              out_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0]            stage_valid;
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]            stage_load;
    logic [DEPTH-1:0]            stage_drain;
    logic [DEPTH:0]              adv;
    logic                        in_fire;
    logic                        out_fire;
    logic                        bypass_act;
    logic                        bypass_take;
    logic [CW-1:0]               count_q, count_d;
    cnt_op_e                     cnt_op;

    // A stage can accept when it is empty or its occupant moves on this cycle.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_rdy;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !stage_valid[i] | adv[i+1];
        end
    end

    assign in_rdy  = !reset & en & !clear & adv[0];
    assign in_fire = in_val & in_rdy;

`ifdef DFFRE_PIPE_VR_BYPASS_EN
    assign bypass_act  = !reset & en & !clear & in_val & (count_q == '0);
    assign bypass_take = bypass_act & out_rdy;
`else
    assign bypass_act  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign out_val  = (en & stage_valid[DEPTH-1]) | bypass_act;
    assign out_data = bypass_act ? in_data : stage_data[DEPTH-1];
    assign out_fire = out_val & out_rdy & !clear;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_val;

        if (g == 0) begin : g_head
            // A bypassed item is consumed at the output and never enters stage 0.
            assign src_data = in_data;
            assign src_val  = in_fire & !bypass_take;
        end else begin : g_body
            assign src_data = stage_data[g-1];
            assign src_val  = stage_valid[g-1];
        end

        assign stage_load[g]  = en & !clear & adv[g] & src_val;
        assign stage_drain[g] = en & !clear & stage_valid[g] & adv[g+1];

        dffre_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear_i (clear),
            .load_i  (stage_load[g]),
            .drain_i (stage_drain[g]),
            .data_i  (src_data),
            .valid_o (stage_valid[g]),
            .data_o  (stage_data[g])
        );
    end

    always_comb begin
        case ({in_fire, out_fire})
            2'b10:   cnt_op = CNT_INC;
            2'b01:   cnt_op = CNT_DEC;
            default: cnt_op = CNT_HOLD;
        endcase

        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else begin
            case (cnt_op)
                CNT_INC: count_d = count_q + CW'(1);
                CNT_DEC: count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
